nx_axbs_acc: RTL and testbench

//  Downstream consumer of the nx_axbs signed multiplier. Accumulates a stream of signed

---
 rtl/nx_axbs_acc_if.sv | 27 ++
 rtl/nx_axbs_acc.sv | 95 +++++++++
 tb/tb_nx_axbs_acc.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/nx_axbs_acc_if.sv
// Product-beat input and result output bundle for nx_axbs_acc.
// slave is the accumulator's view; master is the producer/consumer side.
interface nx_axbs_acc_if #(
  parameter int PROD_W = 64,
  parameter int OUT_W  = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_data;
  logic              in_first;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_sat;
  logic              err_seq;

  modport master (
    output in_valid, in_data, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat, err_seq
  );

  modport slave (
    input  in_valid, in_data, in_first, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat, err_seq
  );
endinterface

// File: rtl/nx_axbs_acc.sv
// Dot-product accumulator for signed multiplier products.
// Rounds, shifts and saturates each vector sum onto a valid/ready port.
module nx_axbs_acc #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,
  parameter int SHIFT  = 16,
  parameter int OUT_W  = 32
) (
  input  logic         clk,
  input  logic         rst,
  nx_axbs_acc_if.slave bus
);
  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [ACC_W:0] ONE  = (ACC_W+1)'(1);
  localparam int             RSH  = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [ACC_W:0] RND  = (SHIFT > 0) ? (ONE << RSH) : '0;
  localparam logic [ACC_W:0] MAXV = (ONE << (OUT_W - 1)) - ONE;
  localparam logic [ACC_W:0] MINV = ~MAXV;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  fin;
  logic              fin_valid;
  logic [ACC_W-1:0]  base;
  logic [ACC_W-1:0]  sum;
  logic              out_en;
  logic              fire;
  logic              move;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] r;
  logic [OUT_W-1:0]  res;
  logic              res_sat;

  assign out_en      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !fin_valid || out_en;
  assign fire        = bus.in_valid && bus.in_ready;
  assign move        = fin_valid && out_en;

  // a first beat restarts the sum even mid-vector
  assign base = (state == ACCUM && !bus.in_first) ? acc : '0;
  assign sum  = base + ACC_W'($signed(bus.in_data));

  // one extra bit keeps the rounding add from wrapping
  assign rnd = $signed({fin[ACC_W-1], fin} + RND);
  assign r   = rnd >>> SHIFT;

  always_comb begin
    res     = r[OUT_W-1:0];
    res_sat = 1'b0;
    if (r > $signed(MAXV)) begin
      res     = MAXV[OUT_W-1:0];
      res_sat = 1'b1;
    end else if (r < $signed(MINV)) begin
      res     = MINV[OUT_W-1:0];
      res_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      acc           <= '0;
      fin           <= '0;
      fin_valid     <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
      bus.err_seq   <= 1'b0;
    end else begin
      if (fire) begin
        if (state == ACCUM && bus.in_first)
          bus.err_seq <= 1'b1;
        if (bus.in_last) begin
          fin   <= sum;
          state <= IDLE;
        end else begin
          acc   <= sum;
          state <= ACCUM;
        end
      end
      if (fire && bus.in_last)
        fin_valid <= 1'b1;
      else if (move)
        fin_valid <= 1'b0;
      if (move) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= res;
        bus.out_sat   <= res_sat;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_nx_axbs_acc.sv
// Directed bench for nx_axbs_acc with SHIFT=0 and SHIFT=16 instances.
// Expected results are queued as vectors are driven and popped on output.
module tb_nx_axbs_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nx_axbs_acc_if #(.PROD_W(64), .OUT_W(32)) b0 ();
  nx_axbs_acc_if #(.PROD_W(64), .OUT_W(32)) b16 ();

  nx_axbs_acc #(.PROD_W(64), .ACC_W(72), .SHIFT(0), .OUT_W(32)) u0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  nx_axbs_acc #(.PROD_W(64), .ACC_W(72), .SHIFT(16), .OUT_W(32)) u16 (
    .clk(clk), .rst(rst), .bus(b16)
  );

  int checks = 0;
  int fails  = 0;
  logic [32:0] q0[$];
  logic [32:0] q16[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && b0.out_valid && b0.out_ready) begin
      if (q0.size() == 0) chk("q0_underflow", 64'(q0.size()), 64'd1);
      else chk("q0_result", 64'({b0.out_sat, b0.out_data}), 64'(q0.pop_front()));
    end
    if (!rst && b16.out_valid && b16.out_ready) begin
      if (q16.size() == 0) chk("q16_underflow", 64'(q16.size()), 64'd1);
      else chk("q16_result", 64'({b16.out_sat, b16.out_data}), 64'(q16.pop_front()));
    end
  end

  task automatic beat(input bit s, input longint d, input bit f, input bit l);
    int n;
    if (s) begin
      b16.in_valid = 1'b1; b16.in_data = d;
      b16.in_first = f; b16.in_last = l;
    end else begin
      b0.in_valid = 1'b1; b0.in_data = d;
      b0.in_first = f; b0.in_last = l;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(s ? b16.in_ready : b0.in_ready) && n < 50);
    if (n >= 50) chk("beat_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    if (s) b16.in_valid = 1'b0;
    else b0.in_valid = 1'b0;
  endtask

  initial begin
    longint t0;
    int n;
    b0.in_valid = 0; b0.in_data = '0; b0.in_first = 0; b0.in_last = 0;
    b16.in_valid = 0; b16.in_data = '0; b16.in_first = 0; b16.in_last = 0;
    b0.out_ready = 1; b16.out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", 64'(b0.in_ready), 64'd1);
    chk("rst_out_valid", 64'(b0.out_valid), 64'd0);
    chk("rst_out_data", 64'(b0.out_data), 64'd0);
    chk("rst_err_seq", 64'(b0.err_seq), 64'd0);
    chk("rst_out_valid16", 64'(b16.out_valid), 64'd0);
    @(posedge clk); #1;

    // reset in the middle of an open vector
    beat(0, 5, 1, 0);
    beat(0, 6, 0, 0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(b0.out_valid), 64'd0);
    chk("midrst_err_seq", 64'(b0.err_seq), 64'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // {3,-5,10} and its latency
    q0.push_back({1'b0, 32'd8});
    beat(0, 3, 1, 0);
    beat(0, -5, 0, 0);
    beat(0, 10, 0, 1);
    chk("lat_edge1", 64'(b0.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_edge2", 64'(b0.out_valid), 64'd1);
    chk("lat_data", 64'(b0.out_data), 64'd8);
    @(posedge clk); #1;

    // rounding at SHIFT=16
    q16.push_back({1'b0, 32'd2});
    q16.push_back({1'b0, 32'hFFFF_FFFF});
    q16.push_back({1'b0, 32'd1});
    beat(1, 64'sh18000, 1, 1);
    beat(1, -64'sh18000, 1, 1);
    beat(1, 64'sh17FFF, 1, 1);

    // saturation boundaries at SHIFT=0
    q0.push_back({1'b1, 32'h7FFF_FFFF});
    q0.push_back({1'b1, 32'h8000_0000});
    q0.push_back({1'b0, 32'h7FFF_FFFF});
    q0.push_back({1'b0, 32'h8000_0000});
    beat(0, 64'sh7FFF_FFFF, 1, 0);
    beat(0, 1, 0, 1);
    beat(0, -64'sh8000_0000, 1, 0);
    beat(0, -1, 0, 1);
    beat(0, 64'sh7FFF_FFFF, 1, 1);
    beat(0, -64'sh8000_0000, 1, 1);
    repeat (3) @(posedge clk);
    #1;

    // backpressure with two results buffered
    b0.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) q0.push_back({1'b0, 32'(i)});
    beat(0, 1, 1, 1);
    beat(0, 2, 1, 1);
    @(negedge clk);
    chk("bp_in_ready", 64'(b0.in_ready), 64'd0);
    chk("bp_out_valid", 64'(b0.out_valid), 64'd1);
    repeat (4) begin
      @(negedge clk);
      chk("bp_hold_data", 64'(b0.out_data), 64'd1);
      chk("bp_hold_ready", 64'(b0.in_ready), 64'd0);
    end
    @(posedge clk); #1;
    b0.out_ready = 1'b1;
    t0 = longint'($time);
    beat(0, 3, 1, 1);
    beat(0, 4, 1, 1);
    beat(0, 5, 1, 1);
    chk("bp_throughput", 64'(longint'($time) - t0), 64'd30);
    repeat (4) @(posedge clk);
    #1;

    // in_first inside an open vector
    chk("seq_err_before", 64'(b0.err_seq), 64'd0);
    q0.push_back({1'b0, 32'd10});
    beat(0, 7, 1, 0);
    beat(0, 9, 0, 0);
    beat(0, 4, 1, 0);
    beat(0, 6, 0, 1);
    @(negedge clk);
    chk("seq_err_set", 64'(b0.err_seq), 64'd1);
    @(posedge clk); #1;
    q0.push_back({1'b0, 32'd1});
    beat(0, 1, 1, 1);
    repeat (3) @(negedge clk);
    chk("seq_err_sticky", 64'(b0.err_seq), 64'd1);

    n = 0;
    while ((q0.size() + q16.size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q0", 64'(q0.size()), 64'd0);
    chk("drain_q16", 64'(q16.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
